// File: rtl/gbuff_drain_pkg.sv
// Shared types and constants for the GBUFF_B drain engine.
package gbuff_drain_pkg;

    // Default datapath widths and the row stride shared with the GBUFF_B writer.
    localparam int DEF_WORD_SIZE      = 16;
    localparam int DEF_WORD_ADDR_BITS = 16;
    localparam int GBUFF_ROW_STRIDE   = 16;

    // Output FIFO geometry; the read credit limit equals the depth.
    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_PTR_W = 2;
    localparam int FIFO_CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    // Row lengths above one full stride are treated as a full stride.
    function automatic logic [4:0] clamp_row_len(input logic [4:0] len);
        return (len > 5'd16) ? 5'd16 : len;
    endfunction

endpackage

// File: rtl/gbuff_drain_fifo.sv
// 4-entry synchronous FIFO holding {last, data} words returned from GBUFF_B.
module drain_fifo
    import gbuff_drain_pkg::*;
#(
    parameter int WIDTH = DEF_WORD_SIZE + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [FIFO_CNT_W-1:0] count
);

    logic [FIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0]      mem_q [FIFO_DEPTH];

    // Next pointer and occupancy values from this cycle's push/pop.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the empty flag masks stale entries at the read port.
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign empty   = (count_q == '0);
    assign full    = (count_q == FIFO_CNT_W'(FIFO_DEPTH));
    assign count   = count_q;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/gbuff_drain.sv
// Drain engine: walks GBUFF_B row by row (stride 16), reads each word and
// streams it out on a valid/ready interface with per-row last marking.
module gbuff_drain
    import gbuff_drain_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int ADDR_BITS = DEF_WORD_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [9:0]           n_rows,
    input  logic [4:0]           row_len,
    output logic                 sram_en,
    output logic                 sram_wen,
    output logic [ADDR_BITS-1:0] sram_addr,
    input  logic [WORD_SIZE-1:0] sram_DO,
    output logic                 m_valid,
    output logic [WORD_SIZE-1:0] m_data,
    output logic                 m_last,
    input  logic                 m_ready,
    output logic                 busy,
    output logic                 done
);

    state_t          state_q, state_d;
    logic [9:0]      row_q, row_d;
    logic [3:0]      col_q, col_d;
    logic [9:0]      nrows_q, nrows_d;
    logic [4:0]      len_q, len_d;
    logic            inflight_q, inflight_d;
    logic            inflight_last_q, inflight_last_d;

    logic [4:0]      eff_len;
    logic            last_col;
    logic            last_row;
    logic            credit_ok;
    logic            issue;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic [WORD_SIZE:0]    fifo_rd;

    assign eff_len  = clamp_row_len(row_len);
    assign last_col = ({1'b0, col_q} == (len_q - 5'd1));
    assign last_row = (row_q == (nrows_q - 10'd1));

    // Words buffered plus the word still in the SRAM pipeline must fit the FIFO.
    assign credit_ok = !fifo_full &&
                       (({1'b0, fifo_count} + {3'b000, inflight_q}) < 4'(FIFO_DEPTH));
    assign issue     = (state_q == ST_RUN) && credit_ok;
    assign pop       = m_valid && m_ready;

    // FSM next state, row/col walk and read-pipeline tracking.
    always_comb begin
        state_d         = state_q;
        row_d           = row_q;
        col_d           = col_q;
        nrows_d         = nrows_q;
        len_d           = len_q;
        inflight_d      = issue;
        inflight_last_d = last_col;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    nrows_d = n_rows;
                    len_d   = eff_len;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = ((n_rows == '0) || (eff_len == '0)) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    if (last_col && last_row) begin
                        state_d = ST_FLUSH;
                    end else if (last_col) begin
                        col_d = '0;
                        row_d = row_q + 10'd1;
                    end else begin
                        col_d = col_q + 4'd1;
                    end
                end
            end
            ST_FLUSH: begin
                // The final word is the only one left once nothing is in flight.
                if (pop && (fifo_count == FIFO_CNT_W'(1)) && !inflight_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and the one-deep read pipeline flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            row_q           <= '0;
            col_q           <= '0;
            nrows_q         <= '0;
            len_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            row_q           <= row_d;
            col_q           <= col_d;
            nrows_q         <= nrows_d;
            len_q           <= len_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    drain_fifo #(
        .WIDTH (WORD_SIZE + 1)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (inflight_q),
        .wr_data ({inflight_last_q, sram_DO}),
        .pop     (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign sram_en   = issue;
    assign sram_wen  = 1'b0;
    assign sram_addr = ADDR_BITS'(row_q) * ADDR_BITS'(GBUFF_ROW_STRIDE) + ADDR_BITS'(col_q);

    assign m_valid = !fifo_empty;
    assign m_last  = fifo_rd[WORD_SIZE];
    assign m_data  = fifo_rd[WORD_SIZE-1:0];

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_gbuff_drain.sv
// Directed bench for gbuff_drain with a read-latency-1 SRAM holding mem[a]=a.
module tb_gbuff_drain;

    localparam int WS = 16;
    localparam int AB = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [9:0]    n_rows = '0;
    logic [4:0]    row_len = '0;
    logic          sram_en;
    logic          sram_wen;
    logic [AB-1:0] sram_addr;
    logic [WS-1:0] sram_DO = '0;
    logic          m_valid;
    logic [WS-1:0] m_data;
    logic          m_last;
    logic          m_ready = 1'b0;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    gbuff_drain #(
        .WORD_SIZE (WS),
        .ADDR_BITS (AB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n_rows    (n_rows),
        .row_len   (row_len),
        .sram_en   (sram_en),
        .sram_wen  (sram_wen),
        .sram_addr (sram_addr),
        .sram_DO   (sram_DO),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // SRAM model: mem[a] = a, data the cycle after the read strobe.
    always @(posedge clk) begin
        if (sram_en) sram_DO <= sram_addr;
    end

    // Results of the most recent drain run.
    logic [WS-1:0] got_data[$];
    logic          got_last[$];
    int en_count, en_hold, en_resume_cyc, first_valid_cyc, done_cyc;
    int hs_first, hs_last, stall_errs, addr_errs, valid_seen;
    logic post_busy, post_done, en1;
    logic [AB-1:0] addr1;

    // Runs one drain from start (cycle 0) to done, recording what it sees.
    // mode 0: m_ready=1; mode 1: m_ready toggles 1,0,...; mode 2: 0 for hold cycles then 1.
    task automatic drain(input int nr, input int rl, input int mode, input int hold);
        int   eff;
        int   rd_idx;
        int   exp_a;
        logic pv, pr, pl;
        logic [WS-1:0] pd;
        bit   fin;
        eff = (rl > 16) ? 16 : rl;
        rd_idx = 0; pv = 0; pr = 0; pl = 0; pd = '0; fin = 0;
        got_data.delete(); got_last.delete();
        en_count = 0; en_hold = 0; en_resume_cyc = -1; first_valid_cyc = -1; done_cyc = -1;
        hs_first = -1; hs_last = -1; stall_errs = 0; addr_errs = 0; valid_seen = 0;
        en1 = 0; addr1 = '1;
        for (int k = 0; k < 3000 && !fin; k++) begin
            @(negedge clk);
            start   = (k == 0);
            n_rows  = 10'(nr);
            row_len = 5'(rl);
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (k % 2 == 0);
                default: m_ready = (k >= hold);
            endcase
            if (pv && !pr) begin
                if (!m_valid || m_data !== pd || m_last !== pl) stall_errs++;
            end
            if (k == 1) begin
                en1 = sram_en;
                addr1 = sram_addr;
            end
            if (sram_en) begin
                en_count++;
                if (k < hold) en_hold++;
                if (k >= hold && en_resume_cyc < 0) en_resume_cyc = k;
                exp_a = (eff > 0) ? (rd_idx / eff) * 16 + (rd_idx % eff) : -1;
                if (sram_addr !== AB'(exp_a)) addr_errs++;
                rd_idx++;
            end
            if (m_valid) begin
                valid_seen++;
                if (first_valid_cyc < 0) first_valid_cyc = k;
            end
            if (m_valid && m_ready) begin
                got_data.push_back(m_data);
                got_last.push_back(m_last);
                if (hs_first < 0) hs_first = k;
                hs_last = k;
            end
            pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
            if (done) begin
                done_cyc = k;
                fin = 1;
            end
        end
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL drain_timeout nr=%0d rl=%0d: done not seen within 3000 cycles", nr, rl);
        end
        @(negedge clk);
        start = 1'b0;
        post_busy = busy;
        post_done = done;
    endtask

    // Model: number of received words differing from the expected row walk.
    function automatic int stream_errs(input int nr, input int rl);
        int eff, n_exp, n, errs;
        eff   = (rl > 16) ? 16 : rl;
        n_exp = nr * eff;
        n     = got_data.size();
        errs  = (n > n_exp) ? n - n_exp : n_exp - n;
        for (int i = 0; i < n && i < n_exp; i++) begin
            if (got_data[i] !== WS'((i / eff) * 16 + (i % eff))) errs++;
            if (got_last[i] !== ((i % eff) == eff - 1)) errs++;
        end
        return errs;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({sram_en, sram_wen, m_valid, m_last, busy, done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got en,wen,valid,last,busy,done=%b want 000000",
                     {sram_en, sram_wen, m_valid, m_last, busy, done});
        end
        checks++;
        if (sram_addr !== '0 || m_data !== '0) begin
            errors++;
            $display("FAIL reset_buses got addr=%0d data=%0d want 0 0", sram_addr, m_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int e;
        drain(2, 3, 0, 0);
        e = stream_errs(2, 3);
        checks++;
        if (e !== 0) begin errors++; $display("FAIL basic_stream got %0d bad words want 0", e); end
        checks++;
        if ({en1, addr1} !== {1'b1, AB'(0)}) begin
            errors++; $display("FAIL basic_first_read got en=%b addr=%0d want en=1 addr=0", en1, addr1);
        end
        checks++;
        if (first_valid_cyc !== 3) begin
            errors++; $display("FAIL basic_first_valid got cycle %0d want 3", first_valid_cyc);
        end
        checks++;
        if (done_cyc !== 9 || done_cyc !== hs_last + 1) begin
            errors++; $display("FAIL basic_done got cycle %0d (last hs %0d) want 9", done_cyc, hs_last);
        end
        checks++;
        if (en_count !== 6 || addr_errs !== 0) begin
            errors++; $display("FAIL basic_reads got %0d reads %0d bad addr want 6 0", en_count, addr_errs);
        end
        checks++;
        if ({post_busy, post_done} !== 2'b00) begin
            errors++; $display("FAIL basic_return_idle got busy,done=%b want 00", {post_busy, post_done});
        end
    endtask

    task automatic test_toggle_ready;
        int e;
        drain(2, 3, 1, 0);
        e = stream_errs(2, 3);
        checks++;
        if (e !== 0) begin errors++; $display("FAIL toggle_stream got %0d bad words want 0", e); end
        checks++;
        if (stall_errs !== 0) begin errors++; $display("FAIL toggle_stall_stable got %0d unstable want 0", stall_errs); end
        checks++;
        if (addr_errs !== 0) begin errors++; $display("FAIL toggle_addr got %0d bad addr want 0", addr_errs); end
    endtask

    task automatic test_backpressure;
        int e;
        drain(1, 8, 2, 20);
        checks++;
        if (en_hold !== 4) begin errors++; $display("FAIL bp_reads_held got %0d reads want 4", en_hold); end
        checks++;
        if (en_resume_cyc !== 21) begin
            errors++; $display("FAIL bp_resume got cycle %0d want 21", en_resume_cyc);
        end
        e = stream_errs(1, 8);
        checks++;
        if (e !== 0) begin errors++; $display("FAIL bp_stream got %0d bad words want 0", e); end
        checks++;
        if (stall_errs !== 0) begin errors++; $display("FAIL bp_stall_stable got %0d unstable want 0", stall_errs); end
    endtask

    task automatic test_zero_size;
        drain(0, 3, 0, 0);
        checks++;
        if (done_cyc !== 1 || en_count !== 0 || valid_seen !== 0) begin
            errors++; $display("FAIL zero_rows got done=%0d reads=%0d valids=%0d want 1 0 0",
                               done_cyc, en_count, valid_seen);
        end
        drain(2, 0, 0, 0);
        checks++;
        if (done_cyc !== 1 || en_count !== 0 || valid_seen !== 0) begin
            errors++; $display("FAIL zero_len got done=%0d reads=%0d valids=%0d want 1 0 0",
                               done_cyc, en_count, valid_seen);
        end
    endtask

    task automatic test_full_frame(input int rl);
        int e;
        drain(8, rl, 0, 0);
        e = stream_errs(8, 16);
        checks++;
        if (e !== 0 || got_data.size() !== 128) begin
            errors++; $display("FAIL frame%0d_stream got %0d words %0d bad want 128 0", rl, got_data.size(), e);
        end
        checks++;
        if (hs_first !== 3 || hs_last !== 130) begin
            errors++; $display("FAIL frame%0d_throughput got hs %0d..%0d want 3..130", rl, hs_first, hs_last);
        end
        checks++;
        if (addr_errs !== 0 || en_count !== 128) begin
            errors++; $display("FAIL frame%0d_addr got %0d reads %0d bad want 128 0", rl, en_count, addr_errs);
        end
        checks++;
        if (done_cyc !== 131) begin errors++; $display("FAIL frame%0d_done got cycle %0d want 131", rl, done_cyc); end
    endtask

    task automatic test_rst_mid;
        int hs;
        bit fired;
        int e;
        hs = 0; fired = 0;
        for (int k = 0; k < 200 && !fired; k++) begin
            @(negedge clk);
            start = (k == 0); n_rows = 10'd2; row_len = 5'd16; m_ready = 1'b1;
            if (m_valid && m_ready) hs++;
            if (hs == 5) fired = 1;
        end
        checks++;
        if (!fired) begin errors++; $display("FAIL rst_mid_reach got %0d transfers want 5", hs); end
        @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({m_valid, busy, sram_en} !== 3'b000) begin
            errors++; $display("FAIL rst_mid_clear got valid,busy,en=%b want 000", {m_valid, busy, sram_en});
        end
        rst = 1'b0;
        drain(1, 4, 0, 0);
        e = stream_errs(1, 4);
        checks++;
        if (e !== 0 || {en1, addr1} !== {1'b1, AB'(0)}) begin
            errors++; $display("FAIL rst_mid_restart got %0d bad words first en=%b addr=%0d want 0 1 0", e, en1, addr1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle_ready();
        test_backpressure();
        test_zero_size();
        test_full_frame(16);
        test_full_frame(20);
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
